// File: rtl/seq_restoring_divider_pkg.sv
// Shared constants for the sequential restoring divider: state encoding and default width.
package seq_restoring_divider_pkg;

  localparam int DEFAULT_N = 20;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ENA   = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_CALC  = 3'd3;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division step: conditionally subtract the divisor from the partial remainder.
module seq_restoring_divider_div_step
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] y_i,
  output logic [N-1:0] a_o,
  output logic         q_bit_o
);

  always_comb begin
    a_o     = a_i;
    q_bit_o = 1'b0;
    if (a_i >= y_i) begin
      a_o     = a_i - y_i;
      q_bit_o = 1'b1;
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, armed by sen1 and launched by sen2; one quotient
// bit per SHIFT/CALC pair, result published in Q with done on the final CALC.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         sen1,
  input  logic         sen2,
  output logic [N-1:0] Q,
  output logic         done,
  output state_t       state_o
);

  localparam int COUNT_WIDTH = $clog2(N) + 1;

  state_t                 state_q, state_d;
  logic [N-1:0]           a_q, a_d;
  logic [N-1:0]           x_q, x_d;
  logic [N-1:0]           y_q, y_d;
  logic [N-1:0]           wq_q, wq_d;
  logic [N-1:0]           q_q, q_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [N-1:0] step_a;
  logic         step_bit;

  seq_restoring_divider_div_step #(.N(N)) u_step (
    .a_i    (a_q),
    .y_i    (y_q),
    .a_o    (step_a),
    .q_bit_o(step_bit)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    wq_d    = wq_q;
    q_d     = q_q;
    done_d  = done_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (sen1) state_d = ST_ENA;
      end
      ST_ENA: begin
        // Operands are re-sampled every ENA cycle, so the launch edge captures the latest ones.
        x_d     = dividend;
        y_d     = divisor;
        a_d     = '0;
        wq_d    = '0;
        count_d = '0;
        done_d  = 1'b0;
        if (sen2) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {a_d, x_d} = {a_q, x_q} << 1;
        wq_d       = wq_q << 1;
        state_d    = ST_CALC;
      end
      ST_CALC: begin
        a_d  = step_a;
        wq_d = {wq_q[N-1:1], step_bit};
        if (count_q == COUNT_WIDTH'(N - 1)) begin
          count_d = '0;
          q_d     = {wq_q[N-1:1], step_bit};
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      wq_q    <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wq_q    <= wq_d;
      q_q     <= q_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign Q       = q_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed plus randomized bench for seq_restoring_divider, checked against plain integer division.
module tb_seq_restoring_divider;
  import seq_restoring_divider_pkg::*;

  localparam int N = 20;
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  // clock / reset
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         sen1 = 1'b0;
  logic         sen2 = 1'b0;
  logic [N-1:0] Q;
  logic         done;
  state_t       state_o;

  always #5 clk = ~clk;

  seq_restoring_divider #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .dividend(dividend),
    .divisor (divisor),
    .sen1    (sen1),
    .sen2    (sen2),
    .Q       (Q),
    .done    (done),
    .state_o (state_o)
  );

  // scoreboard
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_q;
  int           pass_cnt = 0;
  int           total_cnt = 0;

  function automatic logic [N-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return ALL_ONES;
    return a / b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // driver: arm with sen1, hold in ENA for arm_cycles, then launch with final divisor
  task automatic start_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs_early,
                          input logic [N-1:0] dvs, input int arm_cycles);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs_early;
    sen1     = 1'b1;
    sen2     = 1'b0;
    repeat (arm_cycles) @(negedge clk);
    divisor = dvs;
    sen2    = 1'b1;
    exp_q.push_back(ref_div(dvd, dvs));
    @(negedge clk);
    sen1 = 1'b0;
    sen2 = 1'b0;
    check("launch_state", 32'(state_o), 32'(ST_SHIFT));
    check("launch_done_clear", 32'(done), 32'd0);
  endtask

  // waits for done, checks latency and quotient; toggle drives junk on sen1/sen2 meanwhile
  task automatic wait_done(input string tag, input bit toggle);
    int           cyc;
    logic [N-1:0] exp;
    bit           seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 1; k <= 2 * N + 6; k++) begin
      @(negedge clk);
      if (k == N) check({tag, "_q_hold_mid"}, 32'(Q), 32'(last_q));
      if (done) begin
        cyc  = k;
        seen = 1'b1;
        break;
      end
      if (toggle) begin
        sen1 = 1'($urandom_range(0, 1));
        sen2 = 1'($urandom_range(0, 1));
      end
    end
    sen1 = 1'b0;
    sen2 = 1'b0;
    exp  = exp_q.pop_front();
    check({tag, "_latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(2 * N));
    check({tag, "_q"}, 32'(Q), 32'(exp));
    last_q = exp;
  endtask

  initial begin
    logic [31:0] r;
    logic [N-1:0] rd, rv;
    last_q = '0;

    // reset with operands present
    dividend = 20'd25;
    divisor  = 20'd3;
    repeat (3) @(negedge clk);
    check("reset_q", 32'(Q), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(state_o), 32'(ST_IDLE));
    reset = 1'b0;

    start_op(20'd25, 20'd3, 20'd3, 1);
    wait_done("d25_3", 1'b0);

    start_op(20'd14400, 20'd480, 20'd480, 1);
    wait_done("d14400_480", 1'b0);
    repeat (4) @(negedge clk);
    check("idle_hold_q", 32'(Q), 32'd30);
    check("idle_hold_done", 32'(done), 32'd1);
    check("idle_state", 32'(state_o), 32'(ST_IDLE));

    // back-to-back
    start_op(20'd14400, 20'd7, 20'd7, 1);
    wait_done("d14400_7", 1'b0);
    start_op(20'd14400, 20'd1000, 20'd1000, 1);
    wait_done("d14400_1000", 1'b0);
    start_op(20'd14400, 20'd1048000, 20'd1048000, 1);
    wait_done("d_small_over_big", 1'b0);

    // divide by zero and max operand
    start_op(20'd12345, 20'd0, 20'd0, 1);
    wait_done("div0", 1'b0);
    start_op(ALL_ONES, 20'd1, 20'd1, 1);
    wait_done("max_div1", 1'b0);

    // reset mid-operation
    start_op(20'd14400, 20'd480, 20'd480, 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_q", 32'(Q), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_state", 32'(state_o), 32'(ST_IDLE));
    void'(exp_q.pop_front());
    last_q = '0;
    @(negedge clk);
    reset = 1'b0;
    start_op(20'd14400, 20'd480, 20'd480, 1);
    wait_done("after_reset", 1'b0);

    // hold in ENA while divisor changes, then launch; toggle handshakes mid-operation
    start_op(20'd25, 20'd3, 20'd5, 5);
    wait_done("ena_hold_div5", 1'b1);

    // sen2 in IDLE alone does nothing
    @(negedge clk);
    sen2 = 1'b1;
    repeat (3) @(negedge clk);
    check("sen2_idle_state", 32'(state_o), 32'(ST_IDLE));
    check("sen2_idle_done", 32'(done), 32'd1);
    sen2 = 1'b0;

    // randomized operands; divisor kept within the range the N-bit remainder covers
    for (int i = 0; i < 8; i++) begin
      r  = $urandom;
      rd = r[N-1:0];
      r  = $urandom_range(0, 1 << (N - 1));
      rv = r[N-1:0];
      if (i == 3) rv = '0;
      start_op(rd, rv, rv, $urandom_range(1, 3));
      wait_done($sformatf("rand%0d", i), i[0]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider: Q = floor(dividend / divisor), one quotient bit per SHIFT+CALC cycle pair.
- Started by a two-step handshake: sen1 arms the block, sen2 launches the division.
- `done` flags a valid quotient.
- Sits between a measurement front-end that supplies operands and a consumer of the ratio result.

Parameters:
- N, default 20, operand and quotient width in bits (minimum 2).
- COUNT_WIDTH, default $clog2(N)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- dividend  input  N  unsigned numerator; sampled in ENA.
- divisor  input  N  unsigned denominator; sampled in ENA.
- sen1  input  1  arm request: IDLE -> ENA.
- sen2  input  1  launch request: ENA -> SHIFT.
- Q  output  N  unsigned quotient; registered.
- done  output  1  high when Q holds a completed result; registered.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; Q=0; done=0.
  - Internal A (partial remainder), X (dividend shift register), Y (divisor) and count all 0.
  - Reset mid-operation aborts immediately; no partial result is exposed.
- FSM states: IDLE, ENA, SHIFT, CALC. All transitions occur on the rising edge of clk.
  - IDLE: sen1=1 -> ENA; else stay. Q and done hold.
  - ENA: every cycle, load X=dividend, Y=divisor, A=0, count=0, and clear done.
    - sen2=1 -> SHIFT; else stay.
    - Operands present on the edge that leaves ENA are the ones divided.
  - SHIFT: {A,X} <= {A,X} << 1, with 0 shifted into the X LSB; working quotient shifted left by 1. Next state is CALC.
  - CALC: if A >= Y then A <= A - Y and the working quotient LSB is set to 1; count increments.
    - If count == N-1 (the Nth CALC): count resets to 0, Q <= final working quotient, done <= 1, next state IDLE.
    - Otherwise next state is SHIFT.
- Latency: the edge leaving ENA is edge 0. Q and done update on edge 2N. For N=20, done rises 40 cycles after launch.
- done stays high through IDLE. It is cleared only on the first cycle in ENA of the next operation.
- Q holds the last result until the next completion and never shows intermediate values.
- Width rules:
  - A, X, Y and the working quotient are all N bits.
  - The A >= Y comparison is unsigned.
  - The subtraction never underflows.
- Divide by zero: A >= 0 is always true, so Q = all ones (2^N-1); done is asserted normally. No error flag.
- dividend < divisor: Q = 0.
- sen1/sen2 during SHIFT/CALC are ignored; an operation cannot be restarted except by reset.
- If sen1 is still high in IDLE after completion, a new ENA begins on the next edge. Callers drop sen1/sen2 once done is seen.
- sen2 asserted while in IDLE has no effect until ENA is reached.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE=0, ENA=1, SHIFT=2, CALC=3, 3-bit state type);
  - the default width constant.
- One optional sub-module, div_step: combinational compare-subtract taking A and Y and returning the new A and the quotient bit.
- FSM, counter and registers stay in the top module.

Test Plan:
- Reset with operands present, then N=20, dividend=25, divisor=3; sen1 one cycle before sen2 -> done after 2N cycles from launch, Q=8.
- dividend=14400, divisor=480 -> Q=30, done=1. Then drop sen1/sen2 -> Q and done hold in IDLE.
- Back-to-back operations: 14400/7, then after done, 14400/1000, then 14400/1048000 (divisor > dividend) -> Q=2057, 14, 0 in turn. done falls on each ENA entry.
- divisor=0, dividend=12345 -> Q=20'hFFFFF, done=1. Also dividend=20'hFFFFF, divisor=1 -> Q=20'hFFFFF.
- Assert reset at cycle 10 of a 14400/480 division -> Q=0, done=0 immediately. A fresh request after reset release -> Q=30.
- Hold sen1=1 with sen2=0 for 5 cycles while changing divisor 3 -> 5, then raise sen2 -> quotient uses divisor 5 (25/5 -> Q=5). Toggle sen1/sen2 mid-operation -> no effect on result or latency.
